// File: rtl/button_event_decoder.sv
// Turns debounced press pulses and the long-hold level into
// single, double, long-press and long-release event strobes.
module button_event_decoder #(
  parameter int GAP_CYCLES = 2048,
  parameter int CNT_W      = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  input  logic long,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic long_release,
  output logic busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT2,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_long_q;
  logic             r_single;
  logic             r_double;
  logic             r_lpress;
  logic             r_lrel;

  logic w_rise;
  logic w_fall;

  assign w_rise = long & ~r_long_q;
  assign w_fall = ~long & r_long_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_long_q <= 1'b0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_lpress <= 1'b0;
      r_lrel   <= 1'b0;
    end else begin
      r_long_q <= long;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_lpress <= 1'b0;
      r_lrel   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_lpress <= 1'b1;
            r_state  <= S_HOLD;
          end else if (pulse) begin
            r_cnt   <= '0;
            r_state <= S_WAIT2;
          end
        end
        // a long rise discards the pending click
        S_WAIT2: begin
          if (w_rise) begin
            r_lpress <= 1'b1;
            r_state  <= S_HOLD;
          end else if (pulse) begin
            r_double <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_cnt == LAST) begin
            r_single <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_fall) begin
            r_lrel  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign single_click = r_single;
  assign double_click = r_double;
  assign long_press   = r_lpress;
  assign long_release = r_lrel;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomised gesture stimulus; a timestamp-based model feeds
// an event queue that a negedge monitor drains.
module tb_button_event_decoder;

  localparam int G = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse = 1'b0;
  logic long = 1'b0;
  logic single_click;
  logic double_click;
  logic long_press;
  logic long_release;
  logic busy;

  always #5 clk = ~clk;

  button_event_decoder #(
    .GAP_CYCLES(G),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pulse(pulse),
    .long(long),
    .single_click(single_click),
    .double_click(double_click),
    .long_press(long_press),
    .long_release(long_release),
    .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;

  localparam logic [3:0] EV_SGL = 4'b1000;
  localparam logic [3:0] EV_DBL = 4'b0100;
  localparam logic [3:0] EV_LP  = 4'b0010;
  localparam logic [3:0] EV_LR  = 4'b0001;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  bit m_pend = 0;
  bit m_hold = 0;
  bit m_prev = 0;
  int m_t0 = 0;

  // Model: a pending click is just the edge number of the first press.
  always @(posedge clk) begin
    bit rise;
    bit fall;
    cyc++;
    if (!rst_n) begin
      m_pend = 0;
      m_hold = 0;
      m_prev = 0;
    end else begin
      rise = long && !m_prev;
      fall = !long && m_prev;
      m_prev = long;
      if (m_hold) begin
        if (fall) begin
          q.push_back('{cyc, EV_LR});
          m_hold = 0;
        end
      end else if (rise) begin
        q.push_back('{cyc, EV_LP});
        m_hold = 1;
        m_pend = 0;
      end else if (m_pend) begin
        if (pulse) begin
          q.push_back('{cyc, EV_DBL});
          m_pend = 0;
        end else if (cyc - m_t0 == G) begin
          q.push_back('{cyc, EV_SGL});
          m_pend = 0;
        end
      end else if (pulse) begin
        m_pend = 1;
        m_t0 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] got;
    if (cyc > 0) begin
      got = {single_click, double_click, long_press, long_release};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_event cyc=%0d got=none want=%b@%0d",
                 cyc, q[0].ev, q[0].cyc);
        void'(q.pop_front());
      end
      if (got != 4'b0) begin
        total++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          bad++;
          $display("FAIL spurious_event cyc=%0d got=%b want=none",
                   cyc, got);
        end else begin
          if (got !== q[0].ev) begin
            bad++;
            $display("FAIL event_kind cyc=%0d got=%b want=%b",
                     cyc, got, q[0].ev);
          end
          void'(q.pop_front());
        end
      end
      total++;
      if (busy !== (m_pend || m_hold)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b",
                 cyc, busy, (m_pend || m_hold));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press();
    pulse = 1'b1;
    step();
    pulse = 1'b0;
  endtask

  task automatic lpress(input int pre, input int hold);
    press();
    idle(pre);
    long = 1'b1;
    idle(hold);
    long = 1'b0;
  endtask

  initial begin
    int r;
    step();
    for (int i = 0; i < 3; i++) begin
      pulse = i[0];
      long = ~i[0];
      step();
    end
    pulse = 1'b0;
    long = 1'b0;
    rst_n = 1'b1;
    idle(5);

    press();
    idle(G + 5);
    press();
    idle(G - 1);
    press();
    idle(5);
    press();
    idle(G);
    press();
    idle(G + 5);
    lpress(1, 39);
    idle(5);

    press();
    idle(3);
    pulse = 1'b1;
    long = 1'b1;
    step();
    pulse = 1'b0;
    idle(5);
    long = 1'b0;
    idle(3);

    press();
    idle(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(G + 5);

    long = 1'b1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    long = 1'b0;
    idle(3);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        press();
        idle($urandom_range(0, 24));
      end else if (r <= 5) begin
        lpress($urandom_range(0, 20), $urandom_range(1, 20));
        idle($urandom_range(0, 5));
      end else if (r == 6) begin
        long = 1'b1;
        idle($urandom_range(1, 4));
        press();
        idle($urandom_range(0, 3));
        long = 1'b0;
        idle(1);
      end else if (r == 7) begin
        press();
        idle($urandom_range(0, G));
        rst_n = 1'b0;
        idle($urandom_range(1, 3));
        rst_n = 1'b1;
      end else if (r == 8) begin
        press();
        idle($urandom_range(G - 2, G + 1));
        press();
        idle($urandom_range(0, 4));
      end else begin
        idle($urandom_range(1, 30));
      end
    end

    pulse = 1'b0;
    long = 1'b0;
    idle(G + 10);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced button event stream into single-click, double-click, long-press and long-release events. It sits directly downstream of the push-button debouncer and consumes that block's one-cycle `pulse` (press detected) and level `long` (button held long enough). It gives the control logic one-cycle, mutually exclusive event strobes, so no consumer has to time button gestures itself.

## Interface
- `GAP_CYCLES`, default 2048: double-click window in clock cycles. Range 2 .. 2^CNT_W - 1.
- `CNT_W`, default 12: width of the gap counter.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `pulse`  in  1: one-cycle strobe from the debouncer on each press.
- `long`  in  1: level from the debouncer, high while the button is held past the long threshold. Falls on release.
- `single_click`  out  1: one-cycle strobe, registered.
- `double_click`  out  1: one-cycle strobe, registered.
- `long_press`  out  1: one-cycle strobe on the rising edge of `long`, registered.
- `long_release`  out  1: one-cycle strobe on the falling edge of `long` while in HOLD, registered.
- `busy`  out  1: high when state is not IDLE. Decoded from the state register.

## Operation
- Registers:
  - `state` in {IDLE, WAIT2, HOLD}.
  - `cnt[CNT_W-1:0]`.
  - `long_q`, the previous `long`, used for edge detection.
  - `rise = long & ~long_q`; `fall = ~long & long_q`.
- The four strobes default to 0 every cycle. At most one strobe is high in any cycle.
- IDLE:
  - `rise` -> `long_press`=1, go to HOLD.
  - Else `pulse` -> `cnt`=0, go to WAIT2.
- WAIT2, priority long rise > pulse > timeout:
  - `rise` -> `long_press`=1, go to HOLD. The pending single click is discarded.
  - Else `pulse` -> `double_click`=1, go to IDLE.
  - Else `cnt == GAP_CYCLES-1` -> `single_click`=1, go to IDLE.
  - Else `cnt` <= `cnt`+1.
- HOLD:
  - `fall` -> `long_release`=1, go to IDLE.
  - `pulse` is ignored in HOLD. The debouncer cannot emit it while `long` is high.
- After a double click, a second press held long yields `double_click` followed later by `long_press`. This is intended.
- Reset (`rst_n`=0 at an edge):
  - `state`=IDLE, `cnt`=0, `long_q`=0, all strobes 0, `busy`=0.
  - Reset applies mid-operation too; any pending click is dropped with no strobe.
  - If `long` is high when reset is released, `rise` fires: `long_press` is strobed the cycle after the first non-reset edge, and the block enters HOLD.
- The counter never wraps, because it exits WAIT2 at `GAP_CYCLES-1`.

## Timing
- Numbering: edge k samples `pulse`=1 in IDLE; `cnt`=j after edge k+j.
- Second-press window: a `pulse` sampled at edges k+1 .. k+GAP_CYCLES counts as a double click. At edge k+GAP_CYCLES, a `pulse` beats the timeout.
- `single_click`: high in the cycle after edge k+GAP_CYCLES. Latency from `pulse` is GAP_CYCLES+1 cycles.
- `double_click`, `long_press`, `long_release`: high in the cycle after the edge that sampled the triggering input. Latency is 1 cycle for `double_click`. For `long_press` and `long_release` it is 1 cycle after `long` changes, since `long_q` is compared at the same edge.
- `busy`: rises in the cycle after the first `pulse` or `rise`. Falls in the same cycle the terminating strobe is high.
- Throughput: a new gesture can start at the edge right after the strobe cycle.

## Test plan
Run all scenarios with GAP_CYCLES=16.
- Reset: hold `rst_n`=0 for 3 cycles with `pulse`/`long` toggling -> all outputs 0, `busy`=0. Release with `long`=0 -> no strobe.
- Single click: one `pulse` at edge 10 -> `single_click`=1 only in the cycle after edge 26, `busy` high over cycles 11..26. No other strobe.
- Double click, window boundary: `pulse` at edge 10 and edge 26 -> `double_click` after edge 26, no `single_click`. A second case with the second `pulse` at edge 27 -> `single_click` after edge 26, and the pulse at 27 starts a new WAIT2.
- Long press: `pulse` at edge 10, `long` high over edges 12..50 -> `long_press` after edge 12, `long_release` after edge 51, no click strobes.
- Priority: `rise` and `pulse` in the same WAIT2 cycle -> `long_press` only, state HOLD.
- Reset mid-WAIT2: `pulse` at edge 10, `rst_n`=0 at edge 15 -> no `single_click` ever, state IDLE, `cnt`=0.
